// File: rtl/fetch_unit_if.sv
// CODE-bus capture controls and architectural outputs of the fetch stage.
// FETCH_INSTR_PC_EN adds the instr_pc trace signal.
interface fetch_unit_if;
    logic [7:0]  code_data;
    logic        pc_en;
    logic        jump_flag;
    logic        pc_add_rel;
    logic        ir_en;
    logic        direct_en;
    logic        rel_en;
    logic        bit_en;
    logic        imm_en;
    logic        addr_hi_en;
    logic        addr_lo_en;
    logic [15:0] pc;
    logic [7:0]  ir;
    logic [7:0]  direct;
    logic [7:0]  rel;
    logic [7:0]  bit_addr;
    logic [7:0]  imm;
    logic [7:0]  addr_hi;
    logic [7:0]  addr_lo;
    logic        instr_done;
    logic [1:0]  bytes_left;
    logic        seq_err;
`ifdef FETCH_INSTR_PC_EN
    logic [15:0] instr_pc;
`endif

    modport master (
        output code_data, pc_en, jump_flag, pc_add_rel, ir_en,
               direct_en, rel_en, bit_en, imm_en, addr_hi_en, addr_lo_en,
        input  pc, ir, direct, rel, bit_addr, imm, addr_hi, addr_lo,
               instr_done, bytes_left, seq_err
`ifdef FETCH_INSTR_PC_EN
        , input instr_pc
`endif
    );

    modport slave (
        input  code_data, pc_en, jump_flag, pc_add_rel, ir_en,
               direct_en, rel_en, bit_en, imm_en, addr_hi_en, addr_lo_en,
        output pc, ir, direct, rel, bit_addr, imm, addr_hi, addr_lo,
               instr_done, bytes_left, seq_err
`ifdef FETCH_INSTR_PC_EN
        , output instr_pc
`endif
    );
endinterface

// File: rtl/fetch_unit.sv
// PC / IR / operand capture stage with MCS-51 instruction-length tracking.
// Optional FETCH_INSTR_PC_EN: records the PC of each captured opcode on instr_pc.
module fetch_unit #(
    parameter logic [15:0] PC_RESET = 16'h0000,
    parameter logic [7:0]  IR_RESET = 8'h00
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.slave  bus
);

    typedef enum logic {OP_WAIT, OPND} state_t;

    state_t      state_reg, state_next;
    logic [15:0] pc_reg, pc_next;
    logic [7:0]  ir_reg;
    logic [1:0]  bytes_left_reg, bytes_left_next;
    logic        instr_done_reg, instr_done_next;
    logic        seq_err_reg, seq_err_next;
    logic [1:0]  op_len;

    // Operand registers, index order: direct, rel, bit, imm, addr_hi, addr_lo
    logic [5:0]  opnd_en;
    logic [7:0]  opnd_reg [6];
    logic        opnd_evt;

    assign opnd_en  = {bus.addr_lo_en, bus.addr_hi_en, bus.imm_en,
                       bus.bit_en, bus.rel_en, bus.direct_en};
    assign opnd_evt = |opnd_en;

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_opnd
            always_ff @(posedge clk) begin
                if (reset)
                    opnd_reg[gi] <= 8'h00;
                else if (opnd_en[gi])
                    opnd_reg[gi] <= bus.code_data;
            end
        end
    endgenerate

    // MCS-51 length table, grouped by low nibble of the opcode
    function automatic logic [1:0] decode_len(input logic [7:0] op);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = op[7:4];
        lo = op[3:0];
        decode_len = 2'd1;
        case (lo)
            4'h0: begin
                if (hi inside {4'h1, 4'h2, 4'h3, 4'h9}) decode_len = 2'd3;
                else if (hi inside {[4'h4:4'hD]})      decode_len = 2'd2;
            end
            4'h1: decode_len = 2'd2;
            4'h2: begin
                if (hi inside {4'h0, 4'h1})            decode_len = 2'd3;
                else if (hi inside {[4'h4:4'hD]})      decode_len = 2'd2;
            end
            4'h3: if (hi inside {4'h4, 4'h5, 4'h6})    decode_len = 2'd3;
            4'h4: begin
                if (hi == 4'hB)                        decode_len = 2'd3;
                else if (hi inside {[4'h2:4'h7], 4'h9}) decode_len = 2'd2;
            end
            4'h5: begin
                if (hi inside {4'h7, 4'h8, 4'hB, 4'hD}) decode_len = 2'd3;
                else if (hi != 4'hA)                   decode_len = 2'd2;
            end
            4'h6, 4'h7: begin
                if (hi == 4'hB)                        decode_len = 2'd3;
                else if (hi inside {4'h7, 4'h8, 4'hA}) decode_len = 2'd2;
            end
            default: begin
                if (hi == 4'hB)                        decode_len = 2'd3;
                else if (hi inside {4'h7, 4'h8, 4'hA, 4'hD}) decode_len = 2'd2;
            end
        endcase
    endfunction

    assign op_len = decode_len(bus.code_data);

    // Jump and relative targets use the operand values from before this edge
    always_comb begin
        pc_next = pc_reg;
        if (bus.pc_en) begin
            if (bus.jump_flag)
                pc_next = {opnd_reg[4], opnd_reg[5]};
            else if (bus.pc_add_rel)
                pc_next = pc_reg + {{8{opnd_reg[1][7]}}, opnd_reg[1]};
            else
                pc_next = pc_reg + 16'd1;
        end
    end

    always_comb begin
        state_next      = state_reg;
        bytes_left_next = bytes_left_reg;
        instr_done_next = 1'b0;
        seq_err_next    = seq_err_reg;
        if (bus.ir_en) begin
            if (state_reg == OPND)
                seq_err_next = 1'b1;
            bytes_left_next = op_len - 2'd1;
            if (op_len == 2'd1) begin
                instr_done_next = 1'b1;
                state_next      = OP_WAIT;
            end else begin
                state_next      = OPND;
            end
        end else if (opnd_evt) begin
            if (state_reg == OPND) begin
                bytes_left_next = bytes_left_reg - 2'd1;
                if (bytes_left_reg == 2'd1) begin
                    instr_done_next = 1'b1;
                    state_next      = OP_WAIT;
                end
            end else begin
                seq_err_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= OP_WAIT;
            pc_reg         <= PC_RESET;
            ir_reg         <= IR_RESET;
            bytes_left_reg <= 2'd0;
            instr_done_reg <= 1'b0;
            seq_err_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            bytes_left_reg <= bytes_left_next;
            instr_done_reg <= instr_done_next;
            seq_err_reg    <= seq_err_next;
            if (bus.ir_en)
                ir_reg <= bus.code_data;
        end
    end

`ifdef FETCH_INSTR_PC_EN
    logic [15:0] instr_pc_reg;

    always_ff @(posedge clk) begin
        if (reset)
            instr_pc_reg <= PC_RESET;
        else if (bus.ir_en)
            instr_pc_reg <= pc_reg;
    end

    assign bus.instr_pc = instr_pc_reg;
`endif

    assign bus.pc         = pc_reg;
    assign bus.ir         = ir_reg;
    assign bus.direct     = opnd_reg[0];
    assign bus.rel        = opnd_reg[1];
    assign bus.bit_addr   = opnd_reg[2];
    assign bus.imm        = opnd_reg[3];
    assign bus.addr_hi    = opnd_reg[4];
    assign bus.addr_lo    = opnd_reg[5];
    assign bus.instr_done = instr_done_reg;
    assign bus.bytes_left = bytes_left_reg;
    assign bus.seq_err    = seq_err_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: PC commands, capture, length tracking.
module tb_fetch_unit;
    logic clk;
    logic reset;
    int   tests;
    int   fails;

    fetch_unit_if bus ();

    fetch_unit #(.PC_RESET(16'h0000), .IR_RESET(8'h00)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        bus.code_data  = 8'h00;
        bus.pc_en      = 1'b0;
        bus.jump_flag  = 1'b0;
        bus.pc_add_rel = 1'b0;
        bus.ir_en      = 1'b0;
        bus.direct_en  = 1'b0;
        bus.rel_en     = 1'b0;
        bus.bit_en     = 1'b0;
        bus.imm_en     = 1'b0;
        bus.addr_hi_en = 1'b0;
        bus.addr_lo_en = 1'b0;
    endtask

    // Apply the currently driven inputs for one edge, then return them to idle
    task automatic tick();
        @(posedge clk);
        #1;
        clear_inputs();
        reset = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("[TB] %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic opcode(input logic [7:0] b);
        bus.ir_en = 1'b1;
        bus.code_data = b;
        tick();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        clear_inputs();
        reset = 1'b1;
        @(negedge clk);
        tick();

        chk("rst_pc", bus.pc, 16'h0000);
        chk("rst_ir", {8'h00, bus.ir}, 16'h0000);
        chk("rst_bytes", {14'd0, bus.bytes_left}, 16'd0);
        chk("rst_done", {15'd0, bus.instr_done}, 16'd0);
        chk("rst_err", {15'd0, bus.seq_err}, 16'd0);
        chk("rst_opnd", {bus.direct | bus.rel | bus.imm, bus.addr_hi | bus.addr_lo | bus.bit_addr}, 16'h0000);

        bus.pc_en = 1'b1; tick(); chk("inc1", bus.pc, 16'h0001);
        bus.pc_en = 1'b1; tick(); chk("inc2", bus.pc, 16'h0002);
        bus.pc_en = 1'b1; tick(); chk("inc3", bus.pc, 16'h0003);

        // MOV dir,dir: three bytes
        opcode(8'h85);
        chk("mov85_ir", {8'h00, bus.ir}, 16'h0085);
        chk("mov85_bl2", {14'd0, bus.bytes_left}, 16'd2);
        chk("mov85_done0", {15'd0, bus.instr_done}, 16'd0);
        bus.direct_en = 1'b1; bus.code_data = 8'h30; tick();
        chk("mov85_bl1", {14'd0, bus.bytes_left}, 16'd1);
        chk("mov85_done1", {15'd0, bus.instr_done}, 16'd0);
        bus.direct_en = 1'b1; bus.code_data = 8'h40; tick();
        chk("mov85_bl0", {14'd0, bus.bytes_left}, 16'd0);
        chk("mov85_direct", {8'h00, bus.direct}, 16'h0040);
        chk("mov85_done2", {15'd0, bus.instr_done}, 16'd1);
        tick();
        chk("mov85_done3", {15'd0, bus.instr_done}, 16'd0);
        chk("mov85_err", {15'd0, bus.seq_err}, 16'd0);

        // MOV DPTR,#0010 then jump
        opcode(8'h90);
        bus.addr_hi_en = 1'b1; bus.code_data = 8'h00; tick();
        bus.addr_lo_en = 1'b1; bus.code_data = 8'h10; tick();
        chk("dptr_done", {15'd0, bus.instr_done}, 16'd1);
        bus.pc_en = 1'b1; bus.jump_flag = 1'b1; tick();
        chk("jmp_0010", bus.pc, 16'h0010);

        // SJMP -2
        opcode(8'h80);
        chk("sjmp_bl", {14'd0, bus.bytes_left}, 16'd1);
        bus.rel_en = 1'b1; bus.code_data = 8'hFE; tick();
        chk("sjmp_done", {15'd0, bus.instr_done}, 16'd1);
        bus.pc_en = 1'b1; bus.pc_add_rel = 1'b1; tick();
        chk("rel_neg", bus.pc, 16'h000E);

        // Same-cycle rel load must not affect this edge's target
        opcode(8'h80);
        bus.rel_en = 1'b1; bus.code_data = 8'h05;
        bus.pc_en = 1'b1; bus.pc_add_rel = 1'b1; tick();
        chk("rel_old", bus.pc, 16'h000C);
        chk("rel_new", {8'h00, bus.rel}, 16'h0005);
        bus.pc_en = 1'b1; bus.pc_add_rel = 1'b1; tick();
        chk("rel_pos", bus.pc, 16'h0011);

        // Wrap FFFF -> 0000
        opcode(8'h90);
        bus.addr_hi_en = 1'b1; bus.code_data = 8'hFF; tick();
        bus.addr_lo_en = 1'b1; bus.code_data = 8'hFF; tick();
        bus.pc_en = 1'b1; bus.jump_flag = 1'b1; tick();
        chk("jmp_ffff", bus.pc, 16'hFFFF);
        bus.pc_en = 1'b1; tick();
        chk("wrap", bus.pc, 16'h0000);

        // Jump priority and pc_en gating
        opcode(8'h02);
        bus.addr_hi_en = 1'b1; bus.code_data = 8'h12; tick();
        bus.addr_lo_en = 1'b1; bus.code_data = 8'h34; tick();
        chk("ljmp_done", {15'd0, bus.instr_done}, 16'd1);
        bus.jump_flag = 1'b1; bus.pc_add_rel = 1'b1; tick();
        chk("pc_hold", bus.pc, 16'h0000);
        bus.pc_en = 1'b1; bus.jump_flag = 1'b1; bus.pc_add_rel = 1'b1; tick();
        chk("jmp_prio", bus.pc, 16'h1234);

        // Two enables in one cycle count as a single operand event
        opcode(8'h75);
        bus.direct_en = 1'b1; bus.imm_en = 1'b1; bus.code_data = 8'h55; tick();
        chk("multi_bl", {14'd0, bus.bytes_left}, 16'd1);
        chk("multi_regs", {bus.direct, bus.imm}, 16'h5555);
        bus.imm_en = 1'b1; bus.code_data = 8'h66; tick();
        chk("multi_done", {15'd0, bus.instr_done}, 16'd1);
        chk("multi_imm", {8'h00, bus.imm}, 16'h0066);
        chk("multi_err", {15'd0, bus.seq_err}, 16'd0);

        // Back-to-back 1-byte opcodes pulse twice
        opcode(8'h00);
        chk("b2b_done1", {15'd0, bus.instr_done}, 16'd1);
        opcode(8'hA5);
        chk("b2b_done2", {15'd0, bus.instr_done}, 16'd1);
        chk("b2b_a5_bl", {14'd0, bus.bytes_left}, 16'd0);

        // Opcode while operands outstanding
        opcode(8'h02);
        chk("abandon_bl", {14'd0, bus.bytes_left}, 16'd2);
        opcode(8'h00);
        chk("abandon_err", {15'd0, bus.seq_err}, 16'd1);
        chk("abandon_done", {15'd0, bus.instr_done}, 16'd1);
        chk("abandon_bl0", {14'd0, bus.bytes_left}, 16'd0);
        tick();
        chk("sticky_err", {15'd0, bus.seq_err}, 16'd1);
        chk("sticky_done", {15'd0, bus.instr_done}, 16'd0);

        // Stray operand in OP_WAIT still loads the register
        bus.bit_en = 1'b1; bus.code_data = 8'h77; tick();
        chk("stray_bit", {8'h00, bus.bit_addr}, 16'h0077);
        chk("stray_done", {15'd0, bus.instr_done}, 16'd0);

        // Reset mid-instruction
        opcode(8'h12);
        chk("mid_bl", {14'd0, bus.bytes_left}, 16'd2);
        reset = 1'b1; bus.direct_en = 1'b1; bus.code_data = 8'h99; bus.pc_en = 1'b1; tick();
        chk("mid_rst_bl", {14'd0, bus.bytes_left}, 16'd0);
        chk("mid_rst_done", {15'd0, bus.instr_done}, 16'd0);
        chk("mid_rst_err", {15'd0, bus.seq_err}, 16'd0);
        chk("mid_rst_pc", bus.pc, 16'h0000);
        chk("mid_rst_direct", {8'h00, bus.direct}, 16'h0000);

`ifdef FETCH_INSTR_PC_EN
        opcode(8'h02);
        bus.addr_hi_en = 1'b1; bus.code_data = 8'h02; tick();
        bus.addr_lo_en = 1'b1; bus.code_data = 8'h00; tick();
        chk("ipc_pre", bus.instr_pc, 16'h0000);
        bus.pc_en = 1'b1; bus.jump_flag = 1'b1; tick();
        chk("ipc_pc", bus.pc, 16'h0200);
        opcode(8'h74);
        chk("ipc_op", bus.instr_pc, 16'h0200);
        bus.pc_en = 1'b1; tick();
        chk("ipc_inc", bus.pc, 16'h0201);
        chk("ipc_hold1", bus.instr_pc, 16'h0200);
        bus.imm_en = 1'b1; bus.code_data = 8'h3C; tick();
        chk("ipc_done", {15'd0, bus.instr_done}, 16'd1);
        chk("ipc_hold2", bus.instr_pc, 16'h0200);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
